var_delay_buffer: RTL and testbench
===================================

Name: var_delay_buffer

Overview:
- Programmable-depth delay line for complex (re/im) sample streams.
- Successor to the fixed shift-register delay: a circular RAM with runtime-selectable delay, strobe-gated advance, fill tracking and a flush control.
- Sits between the sample front end and the ANC adaptive filter, aligning the reference path with the secondary path.

Parameters:
- WIDTH, 32, bits per real/imag component.
- MAX_DEPTH, 64, number of storage entries; must be a power of 2, at least 2.
- DW, $clog2(MAX_DEPTH), width of the delay select (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; the buffer advances only on cycles with en=1.
- flush  input  1  synchronous clear of history/fill state.
- delay  input  DW  requested delay D in strobes, 0..MAX_DEPTH-1.
- data_in_re  input  WIDTH  real input sample.
- data_in_im  input  WIDTH  imag input sample.
- data_out_re  output  WIDTH  delayed real sample, registered.
- data_out_im  output  WIDTH  delayed imag sample, registered.
- out_stb  output  1  one-cycle pulse: outputs were updated this cycle.
- out_valid  output  1  level: current output is a real sample (not zero-fill).

Behaviour:
- Reset (reset=0, async), all to 0:
  - wr_ptr, fill_cnt, data_out_re/im, out_stb, out_valid.
  - RAM contents are not reset.
- Strobe k (en=1, flush=0), D = delay sampled this cycle:
  - mem[wr_ptr] <= input.
  - wr_ptr <= wr_ptr+1, wrapping modulo MAX_DEPTH.
  - fill_cnt <= min(fill_cnt+1, MAX_DEPTH).
  - data_out <= sample k-D if fill_cnt (pre-increment) >= D, else 0.
  - out_valid <= (fill_cnt >= D); out_stb <= 1.
- D=0: current input is bypassed directly into the output register; out_valid=1 from the first strobe.
- D>0: read address is (wr_ptr - D) mod MAX_DEPTH, read before the write of the same cycle. That entry is never wr_ptr, so there is no read/write collision.
- Latency with continuous en: D+1 clocks. D=MAX_DEPTH-1 is equivalent to a fixed MAX_DEPTH-stage shift register.
- en=0: data_out, out_valid, wr_ptr and fill_cnt hold; out_stb=0.
- Delay change takes effect on the next strobe with no flush:
  - Increase beyond available history gives zero output with out_valid=0 until fill_cnt reaches the new D.
  - Decrease is immediately valid.
- flush=1:
  - fill_cnt, wr_ptr, data_out, out_valid and out_stb <= 0 next edge.
  - Wins over a simultaneous en; that input sample is discarded.
- Reset mid-stream: outputs clear immediately (async); history is considered lost (fill_cnt=0).
- fill_cnt saturates at MAX_DEPTH; wr_ptr wraps freely.
- No arithmetic on data; samples pass bit-exact.

Optional Feature:
- Macro: DELAY_BUF_LEVEL_EN.
- Defined:
  - Adds output port fill_level [DW:0] = fill_cnt, registered, reset 0, cleared by flush, saturating at MAX_DEPTH.
  - Adds output port delay_ok = (fill_cnt >= delay), combinational on the current delay input.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
- Bypass: MAX_DEPTH=8, D=0, en=1 continuous, re=1,2,3…, im=-re -> data_out_re=1,2,3 one clock after each input; out_valid=1 from first out_stb.
- Fixed delay: D=5, continuous ramp re=1..20 -> first 5 strobes give out=0 with out_valid=0; strobe 6 gives re=1 with out_valid=1; thereafter out = in-5.
- Gapped strobes: D=3, en pattern 1,0,0,1,1,0,1… with ramp on strobes only -> outputs change only on en cycles, sequence identical to continuous case, out_stb mirrors en delayed by 1.
- Delay change: after 10 strobes at D=2, set D=7 -> next 1 strobe valid with in-7 (fill 10>=7); after flush then D=7 -> 7 zero/invalid strobes.
- Wrap: MAX_DEPTH=8, D=7, 30 strobes -> out = in-7 bit-exact across pointer wraps, fill_cnt saturates at 8.
- Async reset mid-stream: assert reset=0 between clock edges after 12 strobes -> outputs 0 immediately; after release, D=4 requires 4 fresh strobes before out_valid=1.

Source files
------------

// File: rtl/var_delay_buffer.sv
// Circular-RAM delay line for re/im samples; latency delay+1 clocks, advances only on en strobes (no backpressure).
// Define DELAY_BUF_LEVEL_EN to expose fill_level and delay_ok.
module var_delay_buffer #(
  parameter  int WIDTH     = 32,
  parameter  int MAX_DEPTH = 64,
  localparam int DW        = $clog2(MAX_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] data_in_re,
  input  logic [WIDTH-1:0] data_in_im,
  output logic [WIDTH-1:0] data_out_re,
  output logic [WIDTH-1:0] data_out_im,
  output logic             out_stb,
  output logic             out_valid
`ifdef DELAY_BUF_LEVEL_EN
  ,
  output logic [DW:0]      fill_level,
  output logic             delay_ok
`endif
);

  localparam logic [DW:0] FULL = MAX_DEPTH[DW:0];

  logic [2*WIDTH-1:0] mem [MAX_DEPTH];
  logic [DW-1:0]      wr_ptr;
  logic [DW-1:0]      rd_addr;
  logic [DW:0]        fill_cnt;
  logic               strobe;
  logic               hist_ok;
  logic [2*WIDTH-1:0] rd_dat;

  assign strobe  = en & ~flush;
  // For delay>0 this entry is always behind wr_ptr, so reading before the write never collides.
  assign rd_addr = wr_ptr - delay;
  assign rd_dat  = mem[rd_addr];
  assign hist_ok = fill_cnt >= {1'b0, delay};

  always_ff @(posedge clk) begin
    if (strobe) begin
      mem[wr_ptr] <= {data_in_re, data_in_im};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      data_out_re <= '0;
      data_out_im <= '0;
      out_stb     <= 1'b0;
      out_valid   <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      fill_cnt    <= '0;
      data_out_re <= '0;
      data_out_im <= '0;
      out_stb     <= 1'b0;
      out_valid   <= 1'b0;
    end else if (en) begin
      wr_ptr    <= wr_ptr + 1'b1;
      out_stb   <= 1'b1;
      out_valid <= hist_ok;
      if (fill_cnt != FULL) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      // Zero delay bypasses the RAM so the current sample lands in the output register.
      if (delay == '0) begin
        data_out_re <= data_in_re;
        data_out_im <= data_in_im;
      end else if (hist_ok) begin
        {data_out_re, data_out_im} <= rd_dat;
      end else begin
        data_out_re <= '0;
        data_out_im <= '0;
      end
    end else begin
      out_stb <= 1'b0;
    end
  end

`ifdef DELAY_BUF_LEVEL_EN
  assign fill_level = fill_cnt;
  assign delay_ok   = hist_ok;
`endif

endmodule

// File: tb/tb_var_delay_buffer.sv
// Scoreboarded directed bench for var_delay_buffer with MAX_DEPTH=8.
module tb_var_delay_buffer;

  localparam int W = 32;
  localparam int MD = 8;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic         flush = 1'b0;
  logic [2:0]   delay = '0;
  logic [W-1:0] din_re = '0;
  logic [W-1:0] din_im = '0;
  logic [W-1:0] dout_re;
  logic [W-1:0] dout_im;
  logic         out_stb;
  logic         out_valid;
`ifdef DELAY_BUF_LEVEL_EN
  logic [3:0]   fill_level;
  logic         delay_ok;
`endif

  var_delay_buffer #(.WIDTH(W), .MAX_DEPTH(MD)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .flush       (flush),
    .delay       (delay),
    .data_in_re  (din_re),
    .data_in_im  (din_im),
    .data_out_re (dout_re),
    .data_out_im (dout_im),
    .out_stb     (out_stb),
    .out_valid   (out_valid)
`ifdef DELAY_BUF_LEVEL_EN
    ,
    .fill_level  (fill_level),
    .delay_ok    (delay_ok)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  exp_t         exp_q[$];
  logic [W-1:0] hist[$];
  exp_t         ref_o = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe output pops one expectation; between strobes outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (out_stb === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_stb", 128'd1, 128'd0);
      end else begin
        e = exp_q.pop_front();
        chk("out_re", dout_re, e.re);
        chk("out_im", dout_im, e.im);
        chk("out_valid", out_valid, e.v);
        ref_o = e;
      end
    end else begin
      chk("hold", {out_stb, dout_re, dout_im, out_valid}, {1'b0, ref_o.re, ref_o.im, ref_o.v});
    end
  end

  // One driven cycle; a strobe pushes the expected output computed from the sample history.
  task automatic cyc(input logic e, input logic f, input int d, input logic [W-1:0] r);
    exp_t x;
    int   sz;
    @(posedge clk);
    #1;
    en     = e;
    flush  = f;
    delay  = d[2:0];
    din_re = r;
    din_im = -r;
    if (e && !f) begin
      sz = hist.size();
      if (d == 0)       x = '{re: r, im: -r, v: 1'b1};
      else if (sz >= d) x = '{re: hist[sz-d], im: -hist[sz-d], v: 1'b1};
      else              x = '{re: '0, im: '0, v: 1'b0};
      exp_q.push_back(x);
      hist.push_back(r);
      if (hist.size() > 64) void'(hist.pop_front());
    end
  endtask

  // Flush raised together with en: the sample on that cycle must be discarded.
  task automatic do_flush(input int d);
    cyc(1'b1, 1'b1, d, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, d, '0);
    ref_o = '0;
    hist.delete();
  endtask

  task automatic check_last(input string name, input logic [W-1:0] re_req);
    cyc(1'b0, 1'b0, 0, '0);
    @(negedge clk);
    #1;
    chk(name, {dout_re, dout_im, out_valid}, {re_req, -re_req, 1'b1});
  endtask

  initial begin
    logic [14:0] pat;
    int          k;

    #3;
    chk("rst_state", {dout_re, dout_im, out_stb, out_valid}, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Bypass, D=0.
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 0, i);
    check_last("bypass_last", 32'd6);

    // Fixed delay D=5 on a continuous ramp.
    do_flush(5);
    for (int i = 1; i <= 20; i++) cyc(1'b1, 1'b0, 5, i);
    check_last("fixed_last", 32'd15);

    // Gapped strobes, D=3.
    do_flush(3);
    pat = 15'b101100111011001;
    k = 1;
    for (int i = 14; i >= 0; i--) begin
      if (pat[i]) begin
        cyc(1'b1, 1'b0, 3, k);
        k++;
      end else begin
        cyc(1'b0, 1'b0, 3, 32'h5555);
      end
    end
    check_last("gapped_last", k - 1 - 3);

    // Delay change: 10 strobes at D=2, then D=7, then back down to D=1.
    do_flush(2);
    for (int i = 1; i <= 10; i++) cyc(1'b1, 1'b0, 2, 100 + i);
    for (int i = 11; i <= 12; i++) cyc(1'b1, 1'b0, 7, 100 + i);
    for (int i = 13; i <= 14; i++) cyc(1'b1, 1'b0, 1, 100 + i);
    check_last("dec_last", 32'd113);
    do_flush(7);
    for (int i = 1; i <= 9; i++) cyc(1'b1, 1'b0, 7, 200 + i);
    check_last("after_flush_last", 32'd202);

    // Pointer wrap with D=MAX_DEPTH-1.
    do_flush(7);
    for (int i = 1; i <= 30; i++) cyc(1'b1, 1'b0, 7, 32'hA000_0000 + i);
    check_last("wrap_last", 32'hA000_0017);
`ifdef DELAY_BUF_LEVEL_EN
    chk("fill_sat", fill_level, 4'd8);
    chk("delay_ok", delay_ok, 1'b1);
`endif

    // Async reset mid-stream, then D=4 must rebuild history.
    do_flush(4);
    for (int i = 1; i <= 12; i++) cyc(1'b1, 1'b0, 4, 300 + i);
    cyc(1'b0, 1'b0, 4, '0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    ref_o = '0;
    hist.delete();
    #1;
    chk("async_rst", {dout_re, dout_im, out_stb, out_valid}, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 4, 400 + i);
    check_last("post_rst_last", 32'd402);

    repeat (3) cyc(1'b0, 1'b0, 0, '0);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
